// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths and load-type encodings for the MIPS pipeline
package mips_pkg;
   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;
   localparam logic [2:0] LT_LW  = 3'd0;
   localparam logic [2:0] LT_LH  = 3'd1;
   localparam logic [2:0] LT_LHU = 3'd2;
   localparam logic [2:0] LT_LB  = 3'd3;
   localparam logic [2:0] LT_LBU = 3'd4;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: extracts and extends load data from a raw memory word and flags misalignment
module load_align
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    addr_lo,
   input  logic [2:0]    load_type,
   output logic [DW-1:0] data,
   output logic          misalign
);
   logic [15:0] half;
   logic [7:0]  lane;
   assign half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   assign lane = rdata[{addr_lo, 3'b000} +: 8];
   // pick the extended field by load type; reserved codes behave as a full word
   always_comb begin
      data = load_type == LT_LH  ? {{(DW-16){half[15]}}, half} :
             load_type == LT_LHU ? {{(DW-16){1'b0}}, half} :
             load_type == LT_LB  ? {{(DW-8){lane[7]}}, lane} :
             load_type == LT_LBU ? {{(DW-8){1'b0}}, lane} : rdata;
      misalign = (load_type == LT_LH || load_type == LT_LHU) ? addr_lo[0] :
                 (load_type == LT_LB || load_type == LT_LBU) ? 1'b0 : |addr_lo;
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register and writeback; optional retire counter under WB_RETIRE_CNT_EN
module wb_stage
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          in_we,
   input  logic          in_memtoreg,
   input  logic [2:0]    in_load_type,
   input  logic [1:0]    in_addr_lo,
   input  logic [RW-1:0] in_wreg,
   input  logic [DW-1:0] in_alu_result,
   input  logic [DW-1:0] in_mem_rdata,
   output logic [RW-1:0] writeReg,
   output logic [DW-1:0] Din,
   output logic          we,
   output logic          fwd_en,
   output logic [RW-1:0] fwd_reg,
   output logic [DW-1:0] fwd_data,
   output logic          misalign_err,
   output logic [31:0]   retire_cnt
);
   logic          valid, retired, wen_q, mis_q, ld_mis, bad;
   logic [RW-1:0] wreg_q;
   logic [DW-1:0] din_q, ld_data;
   load_align #(.DW(DW)) u_align (
      .rdata    (in_mem_rdata),
      .addr_lo  (in_addr_lo),
      .load_type(in_load_type),
      .data     (ld_data),
      .misalign (ld_mis)
   );
   assign bad = in_valid & in_memtoreg & ld_mis;
   // pipeline register: flush beats stall beats capture; retired marks an entry whose write already went out
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid        <= 1'b0;
         retired      <= 1'b0;
         wen_q        <= 1'b0;
         mis_q        <= 1'b0;
         wreg_q       <= '0;
         din_q        <= '0;
         misalign_err <= 1'b0;
      end else if (flush) begin
         valid        <= 1'b0;
         retired      <= 1'b0;
         misalign_err <= 1'b0;
      end else if (stall) begin
         retired      <= retired | valid;
         misalign_err <= 1'b0;
      end else begin
         valid        <= in_valid;
         retired      <= 1'b0;
         wen_q        <= in_we;
         mis_q        <= bad;
         wreg_q       <= in_wreg;
         din_q        <= in_memtoreg ? ld_data : in_alu_result;
         misalign_err <= bad;
      end
   assign we       = valid & wen_q & (|wreg_q) & ~retired & ~mis_q;
   assign writeReg = wreg_q;
   assign Din      = din_q;
   assign fwd_en   = we;
   assign fwd_reg  = wreg_q;
   assign fwd_data = din_q;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] cnt;
   // count each entry once, on the edge that ends its first cycle in the stage
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (valid & ~retired) cnt <= cnt + 32'd1;
   assign retire_cnt = cnt;
`else
   assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, corner sequences and randomized checks against a transaction-level model
module tb_wb_stage;
   import mips_pkg::*;
   logic        clk = 1'b0, rst, stall, flush, in_valid, in_we, in_memtoreg;
   logic [2:0]  in_load_type;
   logic [1:0]  in_addr_lo;
   logic [4:0]  in_wreg, writeReg, fwd_reg;
   logic [31:0] in_alu_result, in_mem_rdata, Din, fwd_data, retire_cnt;
   logic        we, fwd_en, misalign_err;
   int total = 0, bad = 0;
   logic [31:0] rf [32];
   logic [31:0] mrf [32];
   bit          mv, mwe, mmis, merr;
   int          mage;
   logic [4:0]  mwreg;
   logic [31:0] mdata, mcnt;
`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   typedef struct {
      logic        m;
      logic [2:0]  lt;
      logic [1:0]  a;
      logic [4:0]  r;
      logic [31:0] alu, rd, din;
      logic        w, err;
   } vec_t;
   vec_t vecs [12];

   wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_we(in_we),
      .in_memtoreg(in_memtoreg), .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
      .in_wreg(in_wreg), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
      .writeReg(writeReg), .Din(Din), .we(we), .fwd_en(fwd_en), .fwd_reg(fwd_reg),
      .fwd_data(fwd_data), .misalign_err(misalign_err), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
      else if (we) rf[writeReg] <= Din;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_rf(input string n);
      int bi = -1;
      for (int i = 0; i < 32; i++) if (rf[i] !== mrf[i]) bi = i;
      total++;
      if (bi >= 0) begin
         bad++;
         $display("FAIL %s: rf[%0d]=%h expected %h", n, bi, rf[bi], mrf[bi]);
      end
   endtask

   task automatic model_reset();
      mv = 0; mwe = 0; mmis = 0; merr = 0; mage = 0; mwreg = '0; mdata = '0; mcnt = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
   endtask

   task automatic ld_model(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rd,
                           output logic [31:0] d, output bit mis);
      int sz, sh;
      logic [31:0] v;
      sz = (lt == LT_LH || lt == LT_LHU) ? 2 : (lt == LT_LB || lt == LT_LBU) ? 1 : 4;
      mis = (int'(a) % sz) != 0;
      sh = sz == 4 ? 0 : (int'(a) / sz) * sz * 8;
      v = rd >> sh;
      if (sz == 2) begin
         v = v & 32'h0000FFFF;
         if (lt == LT_LH && v[15]) v = v | 32'hFFFF0000;
      end else if (sz == 1) begin
         v = v & 32'h000000FF;
         if (lt == LT_LB && v[7]) v = v | 32'hFFFFFF00;
      end
      d = v;
   endtask

   task automatic model_edge();
      logic [31:0] d;
      bit mis;
      if (mv && mage == 0) mcnt = mcnt + 1;
      if (flush) begin
         mv = 0; merr = 0;
      end else if (stall) begin
         if (mv) mage++;
         merr = 0;
      end else begin
         ld_model(in_load_type, in_addr_lo, in_mem_rdata, d, mis);
         mv = in_valid; mwe = in_we; mwreg = in_wreg; mage = 0;
         mmis = in_valid && in_memtoreg && mis;
         mdata = in_memtoreg ? d : in_alu_result;
         merr = mmis;
      end
   endtask

   task automatic check_outputs();
      bit ew;
      ew = mv && mwe && mwreg != 0 && mage == 0 && !mmis;
      chk("we", we, ew);
      chk("fwd_en", fwd_en, ew);
      chk("misalign_err", misalign_err, merr);
      chk("retire_cnt", retire_cnt, CNT_EN ? mcnt : 32'd0);
      if (mv && !mmis) begin
         chk("writeReg", writeReg, mwreg);
         chk("Din", Din, mdata);
         chk("fwd_reg", fwd_reg, mwreg);
         chk("fwd_data", fwd_data, mdata);
      end
      if (ew) mrf[mwreg] = mdata;
   endtask

   task automatic drive(input logic s, f, v, w, m, input logic [2:0] lt, input logic [1:0] a,
                        input logic [4:0] r, input logic [31:0] alu, rd);
      stall = s; flush = f; in_valid = v; in_we = w; in_memtoreg = m;
      in_load_type = lt; in_addr_lo = a; in_wreg = r; in_alu_result = alu; in_mem_rdata = rd;
   endtask

   task automatic cyc(input logic s, f, v, w, m, input logic [2:0] lt, input logic [1:0] a,
                      input logic [4:0] r, input logic [31:0] alu, rd);
      drive(s, f, v, w, m, lt, a, r, alu, rd);
      @(posedge clk);
      model_edge();
      #1 check_outputs();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] c0;
      vecs[0]  = '{1'b0, LT_LW,  2'd0, 5'd8,  32'h12345678, 32'h0,        32'h12345678, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, LT_LB,  2'd3, 5'd9,  32'h0,        32'h80FF7F01, 32'hFFFFFF80, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, LT_LBU, 2'd3, 5'd10, 32'h0,        32'h80FF7F01, 32'h00000080, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, LT_LH,  2'd2, 5'd11, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, LT_LHU, 2'd2, 5'd12, 32'h0,        32'h80FF7F01, 32'h000080FF, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, LT_LW,  2'd2, 5'd13, 32'h0,        32'h80FF7F01, 32'h0,        1'b0, 1'b1};
      vecs[6]  = '{1'b1, LT_LW,  2'd0, 5'd14, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, LT_LB,  2'd1, 5'd15, 32'h0,        32'h80FF7F01, 32'h0000007F, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, LT_LH,  2'd1, 5'd16, 32'h0,        32'h80FF7F01, 32'h0,        1'b0, 1'b1};
      vecs[9]  = '{1'b1, 3'd7,   2'd0, 5'd17, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b0};
      vecs[10] = '{1'b1, LT_LBU, 2'd0, 5'd18, 32'h0,        32'h80FF7F01, 32'h00000001, 1'b1, 1'b0};
      vecs[11] = '{1'b0, LT_LW,  2'd0, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0};
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst writeReg", writeReg, 32'd0);
      chk("rst Din", Din, 32'd0);
      chk("rst we", we, 32'd0);
      chk("rst misalign_err", misalign_err, 32'd0);
      chk("rst retire_cnt", retire_cnt, 32'd0);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 1, 1, vecs[i].m, vecs[i].lt, vecs[i].a, vecs[i].r, vecs[i].alu, vecs[i].rd);
         chk($sformatf("vec%0d we", i), we, vecs[i].w);
         chk($sformatf("vec%0d err", i), misalign_err, vecs[i].err);
         if (vecs[i].w) chk($sformatf("vec%0d Din", i), Din, vecs[i].din);
         chk_rf($sformatf("vec%0d rf", i));
      end
      cyc(0, 0, 1, 1, 1, LT_LW, 2'd3, 5'd19, 32'h0, 32'h55555555);
      chk("mis pulse", misalign_err, 32'd1);
      cyc(1, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      chk("mis pulse end", misalign_err, 32'd0);
      chk("mis held we", we, 32'd0);
      cyc(0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd5, 32'hA5A5A5A5, 32'h0);
      chk("stall first we", we, 32'd1);
      c0 = retire_cnt;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd6, 32'h77777777, 32'h0);
         chk($sformatf("stall hold%0d we", k), we, 32'd0);
         chk($sformatf("stall hold%0d reg", k), writeReg, 32'd5);
      end
      chk("stall retire delta", retire_cnt - c0, CNT_EN ? 32'd1 : 32'd0);
      chk_rf("stall rf");
      cyc(1, 1, 1, 1, 0, 3'd0, 2'd0, 5'd7, 32'h01020304, 32'h0);
      chk("flush+stall we", we, 32'd0);
      cyc(0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd20, 32'hCAFEF00D, 32'h0);
      drive(0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd21, 32'h11112222, 32'h0);
      @(posedge clk);
      model_edge();
      #1 check_outputs();
      #1 rst = 1'b1;
      #1;
      chk("async we", we, 32'd0);
      chk("async Din", Din, 32'd0);
      chk("async writeReg", writeReg, 32'd0);
      chk("async retire_cnt", retire_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) cyc(0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd21, 32'h0, 32'h0);
      chk_rf("post reset rf");
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom);
         if (n % 50 == 49) chk_rf("random rf");
      end
      chk_rf("final rf");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
